// File: rtl/ps2_host_tx_if.sv
`timescale 1ns/1ps
// Command/status bundle between a controller and the PS/2 host transmitter.
// The controller holds the master view; the transmitter holds the slave view.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout_err;

  modport master (
    output tx_data,
    output tx_start,
    input  busy,
    input  done,
    input  ack_err,
    input  timeout_err
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    output busy,
    output done,
    output ack_err,
    output timeout_err
  );
endinterface

// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// PS/2 host-to-device command transmitter: clock inhibit, request-to-send,
// device-clocked 11-bit frame, ack check, then wait for both lines idle.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned RTS_CYCLES     = 200,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic             clk,
  input  logic             rst,
  ps2_host_tx_if.slave     bus,
  input  logic             ps2clk_in,
  input  logic             ps2data_in,
  output logic             ps2clk_oe,
  output logic             ps2data_oe
);

  localparam int unsigned MAX_AB  = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 32'd1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t INHIBIT_LAST = cnt_t'(INHIBIT_CYCLES - 32'd1);
  localparam cnt_t RTS_LAST     = cnt_t'(RTS_CYCLES - 32'd1);
  localparam cnt_t TMO_LAST     = cnt_t'(TIMEOUT_CYCLES - 32'd1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RTS       = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  logic       clk_meta_r, clk_sync_r, clk_prev_r;
  logic       data_meta_r, data_sync_r;
  logic       fe_s;
  logic       tmo_active_s, tmo_hit_s;
  state_t     state_r, state_nxt_s;
  cnt_t       cnt_r, cnt_nxt_s;
  logic [3:0] bit_idx_r, bit_idx_nxt_s;
  logic [8:0] shift_r, shift_nxt_s;
  logic       ack_bad_r, ack_bad_nxt_s;
  logic       clk_oe_r, clk_oe_nxt_s;
  logic       data_oe_r, data_oe_nxt_s;
  logic       busy_r, busy_nxt_s;
  logic       done_r, done_nxt_s;
  logic       ack_err_r, ack_err_nxt_s;
  logic       tmo_err_r, tmo_err_nxt_s;

  // Synchronize both raw lines; reset to the idle-high level so no false edge appears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      clk_prev_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2clk_in;
      clk_sync_r  <= clk_meta_r;
      clk_prev_r  <= clk_sync_r;
      data_meta_r <= ps2data_in;
      data_sync_r <= data_meta_r;
    end
  end

  assign fe_s         = clk_prev_r & ~clk_sync_r;
  assign tmo_active_s = (state_r == ST_SEND) || (state_r == ST_ACK) || (state_r == ST_WAIT_IDLE);
  assign tmo_hit_s    = tmo_active_s && (cnt_r == TMO_LAST);

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      bit_idx_r <= 4'd0;
      shift_r   <= 9'd0;
      ack_bad_r <= 1'b0;
      clk_oe_r  <= 1'b0;
      data_oe_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ack_err_r <= 1'b0;
      tmo_err_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      shift_r   <= shift_nxt_s;
      ack_bad_r <= ack_bad_nxt_s;
      clk_oe_r  <= clk_oe_nxt_s;
      data_oe_r <= data_oe_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
      ack_err_r <= ack_err_nxt_s;
      tmo_err_r <= tmo_err_nxt_s;
    end
  end

  // Next-state and next-output logic; the timeout overrides every frame state.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    ack_bad_nxt_s = ack_bad_r;
    clk_oe_nxt_s  = clk_oe_r;
    data_oe_nxt_s = data_oe_r;
    busy_nxt_s    = busy_r;
    done_nxt_s    = 1'b0;
    ack_err_nxt_s = 1'b0;
    tmo_err_nxt_s = 1'b0;

    if (tmo_hit_s) begin
      clk_oe_nxt_s  = 1'b0;
      data_oe_nxt_s = 1'b0;
      busy_nxt_s    = 1'b0;
      tmo_err_nxt_s = 1'b1;
      cnt_nxt_s     = '0;
      state_nxt_s   = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          clk_oe_nxt_s  = 1'b0;
          data_oe_nxt_s = 1'b0;
          if (bus.tx_start) begin
            shift_nxt_s   = {odd_parity(bus.tx_data), bus.tx_data};
            ack_bad_nxt_s = 1'b0;
            busy_nxt_s    = 1'b1;
            clk_oe_nxt_s  = 1'b1;
            cnt_nxt_s     = '0;
            state_nxt_s   = ST_INHIBIT;
          end else begin
            busy_nxt_s = 1'b0;
          end
        end
        ST_INHIBIT: begin
          if (cnt_r == INHIBIT_LAST) begin
            data_oe_nxt_s = 1'b1;
            cnt_nxt_s     = '0;
            state_nxt_s   = ST_RTS;
          end else begin
            cnt_nxt_s = cnt_r + cnt_t'(1);
          end
        end
        ST_RTS: begin
          if (cnt_r == RTS_LAST) begin
            clk_oe_nxt_s  = 1'b0;
            bit_idx_nxt_s = 4'd0;
            cnt_nxt_s     = '0;
            state_nxt_s   = ST_SEND;
          end else begin
            cnt_nxt_s = cnt_r + cnt_t'(1);
          end
        end
        ST_SEND: begin
          cnt_nxt_s = cnt_r + cnt_t'(1);
          // Edges 1..9 shift out data LSB-first then parity; edge 10 releases the stop bit.
          if (fe_s) begin
            if (bit_idx_r == 4'd9) begin
              data_oe_nxt_s = 1'b0;
              state_nxt_s   = ST_ACK;
            end else begin
              data_oe_nxt_s = ~shift_r[0];
              shift_nxt_s   = {1'b0, shift_r[8:1]};
              bit_idx_nxt_s = bit_idx_r + 4'd1;
            end
          end else begin
            bit_idx_nxt_s = bit_idx_r;
          end
        end
        ST_ACK: begin
          cnt_nxt_s = cnt_r + cnt_t'(1);
          if (fe_s) begin
            ack_bad_nxt_s = data_sync_r;
            ack_err_nxt_s = data_sync_r;
            state_nxt_s   = ST_WAIT_IDLE;
          end else begin
            ack_bad_nxt_s = ack_bad_r;
          end
        end
        ST_WAIT_IDLE: begin
          cnt_nxt_s = cnt_r + cnt_t'(1);
          if (clk_sync_r && data_sync_r) begin
            busy_nxt_s  = 1'b0;
            done_nxt_s  = ~ack_bad_r;
            cnt_nxt_s   = '0;
            state_nxt_s = ST_IDLE;
          end else begin
            done_nxt_s = 1'b0;
          end
        end
        default: begin
          clk_oe_nxt_s  = 1'b0;
          data_oe_nxt_s = 1'b0;
          busy_nxt_s    = 1'b0;
          cnt_nxt_s     = '0;
          state_nxt_s   = ST_IDLE;
        end
      endcase
    end
  end

  assign ps2clk_oe       = clk_oe_r;
  assign ps2data_oe      = data_oe_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.ack_err     = ack_err_r;
  assign bus.timeout_err = tmo_err_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// Self-checking bench for ps2_host_tx: a behavioural PS/2 device drives the
// open-drain lines; frames and status pulses are compared with a frame model.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int RTS = 4;
  localparam int TMO = 500;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic dev_abort    = 1'b0;
  int   dev_samples  = 0;
  logic ps2clk_oe, ps2data_oe;
  logic clk_line, data_line;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0, rel_cyc = 0, to_cyc = 0;
  int n_done = 0, n_ack = 0, n_to = 0;

  ps2_host_tx_if bus ();

  assign clk_line  = ~(ps2clk_oe | dev_clk_low);
  assign data_line = ~(ps2data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .RTS_CYCLES    (RTS),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ps2clk_in (clk_line),
    .ps2data_in(data_line),
    .ps2clk_oe (ps2clk_oe),
    .ps2data_oe(ps2data_oe)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame the device should see: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = (($countones(d) % 2) == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  // Status monitor: pulse counting, exclusivity, one-cycle width, busy/done alignment.
  initial begin
    logic p_done, p_ack, p_to, p_busy, p_clk_oe;
    p_done = 1'b0; p_ack = 1'b0; p_to = 1'b0; p_busy = 1'b0; p_clk_oe = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.done || bus.ack_err || bus.timeout_err)
        check_eq("pulse_excl", 32'(bus.done) + 32'(bus.ack_err) + 32'(bus.timeout_err), 32'd1);
      if (bus.done) begin
        n_done++;
        check_eq("done_1cyc", 32'(p_done), 32'd0);
        check_eq("busy_fall_with_done", {30'd0, p_busy, bus.busy}, 32'd2);
      end
      if (bus.ack_err) begin
        n_ack++;
        check_eq("ackerr_1cyc", 32'(p_ack), 32'd0);
      end
      if (bus.timeout_err) begin
        n_to++;
        to_cyc = cyc;
        check_eq("tmo_1cyc", 32'(p_to), 32'd0);
      end
      if (p_clk_oe && !ps2clk_oe) rel_cyc = cyc;
      p_done = bus.done; p_ack = bus.ack_err; p_to = bus.timeout_err;
      p_busy = bus.busy; p_clk_oe = ps2clk_oe;
    end
  end

  // Behavioural keyboard: waits for request-to-send, clocks 11 pulses, samples on rising edges.
  task automatic dev_run(input bit ack_low, input int half, output logic [10:0] seen, output bit ok);
    int w;
    seen = 11'd0;
    ok = 1'b0;
    w = 0;
    while (w < 400 && !(clk_line === 1'b1 && data_line === 1'b0) && !dev_abort) begin
      @(negedge clk);
      w++;
    end
    if (w < 400 && !dev_abort) begin
      ok = 1'b1;
      repeat (half) @(negedge clk);
      seen[0] = data_line;
      dev_samples = 1;
      for (int k = 1; k <= 11; k++) begin
        if (dev_abort) break;
        dev_clk_low = 1'b1;
        repeat (half) @(negedge clk);
        dev_clk_low = 1'b0;
        if (k <= 10) begin
          seen[k] = data_line;
          dev_samples = k + 1;
        end
        repeat (half / 2) @(negedge clk);
        if (k == 10) dev_data_low = ack_low;
        repeat (half - half / 2) @(negedge clk);
      end
    end
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
  endtask

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'($urandom);
  endtask

  // Called on the first negedge after acceptance, which counts as cycle 1.
  task automatic measure_inhibit();
    int run, first_data;
    run = 0;
    first_data = 0;
    for (int i = 1; i <= 60; i++) begin
      if (ps2clk_oe && run == i - 1) run++;
      if (ps2data_oe && first_data == 0) first_data = i;
      @(negedge clk);
    end
    check_eq("clk_oe_len", 32'(run), 32'(INH + RTS));
    check_eq("data_oe_rise_cycle", 32'(first_data), 32'(INH + 1));
  endtask

  task automatic do_send(input logic [7:0] d, input bit ack_low, input bit poke);
    int half, d0, a0, t0, w;
    logic [10:0] seen;
    bit ok;
    half = $urandom_range(6, 12);
    d0 = n_done; a0 = n_ack; t0 = n_to;
    start_tx(d);
    fork
      dev_run(ack_low, half, seen, ok);
      measure_inhibit();
      begin
        if (poke) begin
          repeat (50) @(negedge clk);
          bus.tx_data  = ~d;
          bus.tx_start = 1'b1;
          @(negedge clk);
          bus.tx_start = 1'b0;
        end
      end
    join
    w = 0;
    while (bus.busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    #1;
    check_eq("busy_cleared", 32'(bus.busy), 32'd0);
    check_eq("dev_saw_rts", 32'(ok), 32'd1);
    check_eq("frame_bits", 32'(seen), 32'(ref_frame(d)));
    check_eq("done_count", 32'(n_done - d0), ack_low ? 32'd1 : 32'd0);
    check_eq("ackerr_count", 32'(n_ack - a0), ack_low ? 32'd0 : 32'd1);
    check_eq("tmo_count", 32'(n_to - t0), 32'd0);
    check_eq("lines_released", {30'd0, ps2clk_oe, ps2data_oe}, 32'd0);
  endtask

  task automatic timeout_test();
    int d0, a0, t0, w;
    d0 = n_done; a0 = n_ack; t0 = n_to;
    start_tx(8'hED);
    w = 0;
    while (n_to == t0 && w < 1000) begin
      @(negedge clk);
      #1;
      w++;
    end
    check_eq("tmo_seen", 32'(n_to - t0), 32'd1);
    check_eq("tmo_delay", 32'(to_cyc - rel_cyc), 32'(TMO));
    check_eq("tmo_lines", {30'd0, ps2clk_oe, ps2data_oe}, 32'd0);
    check_eq("tmo_busy", 32'(bus.busy), 32'd0);
    check_eq("tmo_no_done", 32'(n_done - d0), 32'd0);
    check_eq("tmo_no_ackerr", 32'(n_ack - a0), 32'd0);
  endtask

  task automatic reset_test();
    logic [10:0] seen;
    bit ok;
    int w;
    dev_samples = 0;
    start_tx(8'h05);
    fork
      dev_run(1'b1, 8, seen, ok);
      begin
        w = 0;
        while (dev_samples < 5 && w < 1000) begin
          @(negedge clk);
          w++;
        end
        check_eq("rst_reached_bit4", 32'(dev_samples >= 5), 32'd1);
        #2;
        check_eq("pre_rst_oe", {30'd0, ps2clk_oe, ps2data_oe}, 32'd1);
        rst = 1'b0;
        #1;
        check_eq("rst_async_oe", {30'd0, ps2clk_oe, ps2data_oe}, 32'd0);
        check_eq("rst_async_busy", 32'(bus.busy), 32'd0);
        dev_abort = 1'b1;
      end
    join
    dev_abort = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rb;
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("reset_state",
             {26'd0, ps2clk_oe, ps2data_oe, bus.busy, bus.done, bus.ack_err, bus.timeout_err},
             32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    do_send(8'hED, 1'b1, 1'b0);
    do_send(8'h01, 1'b1, 1'b0);
    do_send(8'h00, 1'b1, 1'b0);
    do_send(8'h3C, 1'b0, 1'b0);
    timeout_test();
    reset_test();
    do_send(8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom);
      do_send(rb, ($urandom_range(0, 3) != 0), (i == 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: the sending direction of the keyboard link, opposite to the existing receiver.
- Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) using the standard clock-inhibit / request-to-send sequence.
- Drives the open-drain ps2clk and key_data lines through active-high pull-low enables; the top level builds the tri-states.
- Sits beside receiver r1 in top; `busy` tells the receiver path to discard frames seen while a transmission is in progress.

Parameters:
- INHIBIT_CYCLES, 12000: clk cycles ps2clk is held low before request-to-send (120 us at 100 MHz).
- RTS_CYCLES, 200: clk cycles data is held low before the clock is released (2 us).
- TIMEOUT_CYCLES, 200000: maximum clk cycles from clock release to end of ack (2 ms).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- tx_data  in  8  command byte, captured on accepted tx_start.
- tx_start  in  1  one-cycle request; honoured only in IDLE.
- ps2clk_in  in  1  raw PS/2 clock line (asynchronous).
- ps2data_in  in  1  raw PS/2 data line (asynchronous).
- ps2clk_oe  out  1  1 = pull clock line low, 0 = release.
- ps2data_oe  out  1  1 = pull data line low, 0 = release.
- busy  out  1  high from the accepting cycle until return to IDLE.
- done  out  1  one-cycle pulse: frame sent and device acknowledged.
- ack_err  out  1  one-cycle pulse: data line was high at ack sampling.
- timeout_err  out  1  one-cycle pulse: frame aborted by timeout.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0, so both lines are released; counters and shift register cleared. Reset asserted mid-frame releases both lines immediately.
- ps2clk_in and ps2data_in each pass through a 2-FF synchronizer. A falling edge (fe) is synchronized-previous=1 and synchronized-current=0.
- IDLE:
  - tx_start=1 latches {parity, tx_data}. Parity is odd: ~^tx_data.
  - Next cycle: busy=1, ps2clk_oe=1, state INHIBIT.
  - tx_start while busy is ignored; no queueing.
- INHIBIT: ps2clk_oe=1 for exactly INHIBIT_CYCLES. Then ps2data_oe=1 (start bit), state RTS.
- RTS: hold both oe=1 for RTS_CYCLES. Then ps2clk_oe=0, bit index=0, timeout counter cleared, state SEND.
- SEND, on each fe:
  - fe 1-8: drive tx_data[0..7], LSB first. ps2data_oe = ~bit.
  - fe 9: drive parity the same way.
  - fe 10: ps2data_oe=0 (stop bit released); state ACK.
- ACK, on fe 11: sample synchronized data.
  - 0 -> state WAIT_IDLE.
  - 1 -> ack_err pulse, state WAIT_IDLE.
- WAIT_IDLE: once both synchronized lines are 1, go to IDLE and clear busy.
  - done pulses in the same cycle, only if ack was good.
- Timeout counter runs in SEND, ACK and WAIT_IDLE. Reaching TIMEOUT_CYCLES means:
  - both oe=0;
  - timeout_err pulse;
  - IDLE, busy=0;
  - done and ack_err not pulsed.
- ps2clk_oe is 0 in every state except INHIBIT and RTS. The block never drives a line high.
- done, ack_err and timeout_err are mutually exclusive, and each is high for exactly one cycle.
- fe edges in IDLE, INHIBIT or RTS are ignored.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and acking low. Required:
  - data-line bits seen by the device on rising edges: 0,1,0,1,1,0,1,1,1, parity 1, stop 1;
  - done pulses once; busy falls in the same cycle as done.
- Send 0x01 (parity 0) and 0x00 (parity 1): the parity bit on the line matches; done is asserted for each.
- Set INHIBIT_CYCLES=20 and RTS_CYCLES=4, then assert tx_start.
  - Required: ps2clk_oe high for exactly 24 cycles; ps2data_oe rises at cycle 21.
- Device model leaves data high on fe 11: ack_err pulses once, done stays 0, and the block returns to IDLE.
- Device never clocks, with TIMEOUT_CYCLES=500: timeout_err pulses 500 cycles after clock release, both oe are 0, and busy=0.
- Assert rst low during bit 4, then release it.
  - Required: both oe fall in the same cycle, with no clk edge needed.
  - A subsequent 0xFF send completes with done and parity 1.
